// File: rtl/midi_pkg.sv
// Shared types for the MIDI note display path.
//   MIDI_NOTE_W  : width of a MIDI note number
//   note_slot_t  : one entry of the held-note table {valid, note}
//   disp_state_t : display rotation FSM states
package midi_pkg;

  localparam int MIDI_NOTE_W = 7;

  typedef struct packed {
    logic                   valid;
    logic [MIDI_NOTE_W-1:0] note;
  } note_slot_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    SHOW = 2'd2
  } disp_state_t;

endpackage

// File: rtl/note_display_sched_if.sv
// Event-in / display-out bundle of note_display_sched.
//   ev_valid/ev_on/ev_note : note events from the MIDI byte decoder
//   midi_freq/disp_valid/disp_slot : note currently presented to the lookup
//   active_count/overflow  : table occupancy and dropped-note pulse
//
// Handshake: ev_valid is a one-cycle strobe with no ready/backpressure; the
// receiver accepts ev_on/ev_note on every Clk edge where ev_valid=1. All
// display outputs are registered and always valid to sample (disp_valid
// qualifies midi_freq).
interface note_display_sched_if
  import midi_pkg::*;
#(
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);

  logic                   ev_valid;
  logic                   ev_on;
  logic [MIDI_NOTE_W-1:0] ev_note;
  logic [MIDI_NOTE_W-1:0] midi_freq;
  logic                   disp_valid;
  logic [SLOT_W-1:0]      disp_slot;
  logic [CNT_W-1:0]       active_count;
  logic                   overflow;

  // Event producer (decoder side / testbench).
  modport master (
    output ev_valid, ev_on, ev_note,
    input  midi_freq, disp_valid, disp_slot, active_count, overflow
  );

  // Scheduler side.
  modport slave (
    input  ev_valid, ev_on, ev_note,
    output midi_freq, disp_valid, disp_slot, active_count, overflow
  );

endinterface

// File: rtl/slot_table.sv
// Held-note table. Applies note-on/note-off events, finds matching and free
// slots, flags dropped note-ons and keeps a registered occupancy count.
//   Clk, Reset           : clock, async active-high reset
//   ev_valid/ev_on/ev_note : event strobe and payload
//   slots                : current table contents (registered)
//   active_count         : number of valid slots (registered)
//   overflow             : one-cycle pulse when a note-on found no free slot
module slot_table
  import midi_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             ev_valid,
  input  logic                             ev_on,
  input  logic [MIDI_NOTE_W-1:0]           ev_note,
  output note_slot_t                       slots [NUM_SLOTS],
  output logic [$clog2(NUM_SLOTS+1)-1:0]   active_count,
  output logic                             overflow
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);

  note_slot_t        slots_q    [NUM_SLOTS];
  note_slot_t        slots_next [NUM_SLOTS];
  logic              hit;
  logic [SLOT_W-1:0] hit_idx;
  logic              free;
  logic [SLOT_W-1:0] free_idx;
  logic              overflow_next;
  logic [CNT_W-1:0]  count_next;

  // Match and lowest-free priority: scanning downwards lets the lowest index
  // win. Notes are never duplicated, so at most one slot can match.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slots_q[i].valid && (slots_q[i].note == ev_note)) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
      if (!slots_q[i].valid) begin
        free     = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slots_next[i] = slots_q[i];
    end
    overflow_next = 1'b0;
    if (ev_valid) begin
      if (ev_on) begin
        // A duplicate wins over "full": no write and no overflow.
        if (!hit) begin
          if (free) begin
            slots_next[free_idx].valid = 1'b1;
            slots_next[free_idx].note  = ev_note;
          end else begin
            overflow_next = 1'b1;
          end
        end
      end else if (hit) begin
        slots_next[hit_idx].valid = 1'b0;
      end
    end
  end

  // Count the next table so the count lands on the same edge as the update.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_next = count_next + CNT_W'(slots_next[i].valid);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '0;
      end
      active_count <= '0;
      overflow     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= slots_next[i];
      end
      active_count <= count_next;
      overflow     <= overflow_next;
    end
  end

  assign slots = slots_q;

endmodule

// File: rtl/note_display_sched.sv
// Tracks held MIDI notes and rotates them, one at a time, onto the single
// note-name/octave display path.
//   Clk, Reset : clock, async active-high reset
//   bus        : event inputs and registered display outputs (slave modport)
//   dbg_state  : current rotation FSM state
module note_display_sched
  import midi_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  note_display_sched_if.slave  bus,
  output disp_state_t          dbg_state
);

  localparam int SLOT_W  = $clog2(NUM_SLOTS);
  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  note_slot_t             slots [NUM_SLOTS];

  disp_state_t            state_q, state_next;
  logic [SLOT_W-1:0]      slot_q, slot_next;
  logic [MIDI_NOTE_W-1:0] freq_q, freq_next;
  logic                   valid_q, valid_next;
  logic [DWELL_W-1:0]     dwell_q, dwell_next;

  logic                   any_valid;
  logic                   scan_hit;
  logic [SLOT_W-1:0]      scan_idx;
  logic [SLOT_W-1:0]      cand;

  slot_table #(.NUM_SLOTS(NUM_SLOTS)) u_slot_table (
    .Clk          (Clk),
    .Reset        (Reset),
    .ev_valid     (bus.ev_valid),
    .ev_on        (bus.ev_on),
    .ev_note      (bus.ev_note),
    .slots        (slots),
    .active_count (bus.active_count),
    .overflow     (bus.overflow)
  );

  // Round-robin scan starting just after the shown slot, with the shown slot
  // itself as the last candidate (so a lone note re-selects itself).
  // Iterating from the far end lets the nearest valid slot win.
  always_comb begin
    any_valid = 1'b0;
    scan_hit  = 1'b0;
    scan_idx  = slot_q;
    cand      = '0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      cand = SLOT_W'((int'(slot_q) + k) % NUM_SLOTS);
      if (slots[cand].valid) begin
        any_valid = 1'b1;
        scan_hit  = 1'b1;
        scan_idx  = cand;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    slot_next  = slot_q;
    freq_next  = freq_q;
    valid_next = valid_q;
    dwell_next = dwell_q;
    case (state_q)
      IDLE: begin
        valid_next = 1'b0;
        freq_next  = '0;
        dwell_next = '0;
        if (any_valid) state_next = SEEK;
      end
      SEEK: begin
        if (scan_hit) begin
          slot_next  = scan_idx;
          freq_next  = slots[scan_idx].note;
          valid_next = 1'b1;
          dwell_next = '0;
          state_next = SHOW;
        end else begin
          valid_next = 1'b0;
          freq_next  = '0;
          state_next = IDLE;
        end
      end
      SHOW: begin
        // Leave on dwell expiry or when the shown note was released; the
        // counter holds at its last value through SEEK.
        if ((dwell_q == DWELL_LAST) || !slots[slot_q].valid) begin
          state_next = SEEK;
        end else begin
          dwell_next = dwell_q + DWELL_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_next;
      slot_q  <= slot_next;
      freq_q  <= freq_next;
      valid_q <= valid_next;
      dwell_q <= dwell_next;
    end
  end

  assign bus.midi_freq  = freq_q;
  assign bus.disp_valid = valid_q;
  assign bus.disp_slot  = slot_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_note_display_sched.sv
// Directed testbench for note_display_sched (NUM_SLOTS=4, DWELL_CYCLES=8).
module tb_note_display_sched;
  import midi_pkg::*;

  localparam int NUM_SLOTS = 4;
  localparam int DWELL     = 8;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  note_display_sched_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();
  disp_state_t dbg_state;

  note_display_sched #(
    .NUM_SLOTS    (NUM_SLOTS),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // Expected rotation order (scoreboard queue).
  logic [6:0] exp_q[$];

  // Records whether the dropped note ever reaches the display.
  logic seen_67 = 1'b0;
  always @(negedge Clk) begin
    if (bus.disp_valid && bus.midi_freq == 7'd67) seen_67 = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic on, input logic [6:0] note);
    bus.ev_valid = 1'b1;
    bus.ev_on    = on;
    bus.ev_note  = note;
    tick();
    bus.ev_valid = 1'b0;
    bus.ev_on    = 1'b0;
    bus.ev_note  = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Cycles until midi_freq changes (bounded).
  task automatic wait_change(output int cycles);
    logic [6:0] prev;
    prev   = bus.midi_freq;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.midi_freq == prev && cycles < 40);
  endtask

  task automatic wait_freq(input logic [6:0] f, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.disp_valid && bus.midi_freq == f) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == IDLE) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_freq"},   32'(bus.midi_freq), 0);
    check({tag, "_valid"},  32'(bus.disp_valid), 0);
    check({tag, "_slot"},   32'(bus.disp_slot), 0);
    check({tag, "_count"},  32'(bus.active_count), 0);
    check({tag, "_ovf"},    32'(bus.overflow), 0);
    check({tag, "_state"},  32'(dbg_state), 32'(IDLE));
  endtask

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         c;
    logic       ok;
    logic [6:0] e;

    bus.ev_valid = 1'b0;
    bus.ev_on    = 1'b0;
    bus.ev_note  = '0;

    // Reset values
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("rst");
    Reset = 1'b0;

    // First note: count next cycle, shown two cycles later in slot 0
    send(1'b1, 7'd60);
    check("on60_count", 32'(bus.active_count), 1);
    check("on60_state_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    check("on60_state_seek", 32'(dbg_state), 32'(SEEK));
    tick();
    check("on60_valid", 32'(bus.disp_valid), 1);
    check("on60_freq", 32'(bus.midi_freq), 60);
    check("on60_slot", 32'(bus.disp_slot), 0);
    check("on60_state_show", 32'(dbg_state), 32'(SHOW));

    // Rotation 60 -> 64 -> 67 -> 60, each held DWELL + 1 (SEEK) cycles
    send(1'b1, 7'd64);
    send(1'b1, 7'd67);
    check("rot_count", 32'(bus.active_count), 3);
    wait_change(c);
    check("rot_hold_60", 32'(c + 2), DWELL + 1);
    exp_q.push_back(7'd64);
    exp_q.push_back(7'd67);
    exp_q.push_back(7'd60);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rot_freq", 32'(bus.midi_freq), 32'(e));
      if (exp_q.size() > 0) begin
        wait_change(c);
        check("rot_hold", 32'(c), DWELL + 1);
      end
    end
    check("rot_slot_wrap", 32'(bus.disp_slot), 0);

    // Overflow: fill table, then one note too many
    Reset = 1'b1;
    tick();
    Reset   = 1'b0;
    seen_67 = 1'b0;
    send(1'b1, 7'd60);
    send(1'b1, 7'd62);
    send(1'b1, 7'd64);
    send(1'b1, 7'd65);
    check("full_count", 32'(bus.active_count), 4);
    check("full_no_ovf", 32'(bus.overflow), 0);
    send(1'b1, 7'd67);
    check("ovf_pulse", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.active_count), 4);
    tick();
    check("ovf_one_cycle", 32'(bus.overflow), 0);
    send(1'b1, 7'd62);
    check("dup_full_no_ovf", 32'(bus.overflow), 0);
    check("dup_full_count", 32'(bus.active_count), 4);

    // Release the displayed note: stale for two cycles, then next slot
    wait_freq(7'd64, 60, ok);
    check("wait_64", 32'(ok), 1);
    send(1'b0, 7'd64);
    check("rel64_stale", 32'(bus.midi_freq), 64);
    check("rel64_count", 32'(bus.active_count), 3);
    tick();
    check("rel64_seek", 32'(dbg_state), 32'(SEEK));
    tick();
    check("rel64_next_freq", 32'(bus.midi_freq), 65);
    check("rel64_next_slot", 32'(bus.disp_slot), 3);

    // Note-off of an absent note changes nothing
    send(1'b0, 7'd72);
    check("off72_count", 32'(bus.active_count), 3);
    check("off72_ovf", 32'(bus.overflow), 0);
    check("off72_freq", 32'(bus.midi_freq), 65);

    // Release all -> blank and IDLE
    send(1'b0, 7'd60);
    send(1'b0, 7'd62);
    send(1'b0, 7'd65);
    check("empty_count", 32'(bus.active_count), 0);
    wait_idle(10, ok);
    check("empty_idle", 32'(ok), 1);
    check("empty_valid", 32'(bus.disp_valid), 0);
    check("empty_freq", 32'(bus.midi_freq), 0);
    check("never_shown_67", 32'(seen_67), 0);

    // New note after emptying lands in slot 0
    send(1'b1, 7'd48);
    tick();
    tick();
    check("on48_valid", 32'(bus.disp_valid), 1);
    check("on48_freq", 32'(bus.midi_freq), 48);
    check("on48_slot", 32'(bus.disp_slot), 0);

    // Async reset mid-dwell with three notes held
    send(1'b1, 7'd50);
    send(1'b1, 7'd52);
    repeat (3) tick();
    check("pre_rst_count", 32'(bus.active_count), 3);
    #3;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #2;
    Reset = 1'b0;
    tick();
    check("post_rst_count", 32'(bus.active_count), 0);
    send(1'b1, 7'd70);
    check("on70_count", 32'(bus.active_count), 1);
    tick();
    tick();
    check("on70_freq", 32'(bus.midi_freq), 70);
    check("on70_slot", 32'(bus.disp_slot), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
